// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider.
package div_pkg;

    // Default divisor / quotient / remainder width; the dividend is twice this.
    localparam int DIV_WIDTH = 18;

    // Iteration counter width for the default width.
    localparam int DIV_CNT_W = $clog2(DIV_WIDTH + 1);

    // Divider control states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } div_state_e;

endpackage : div_pkg

// File: rtl/div_step.sv
// One restoring-division iteration: shift one dividend bit into the partial
// remainder and subtract the divisor when the trial value is large enough.
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] rem,
    input  logic             in_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic             qbit
);

    logic [WIDTH:0] trial_s;
    logic [WIDTH:0] diff_s;

    // Compare and subtract at WIDTH+1 bits so the shifted-out MSB is never lost.
    always_comb begin
        trial_s = {rem, in_bit};
        diff_s  = trial_s - {1'b0, divisor};
        if (trial_s >= {1'b0, divisor}) begin
            qbit     = 1'b1;
            rem_next = diff_s[WIDTH-1:0];
        end else begin
            qbit     = 1'b0;
            rem_next = trial_s[WIDTH-1:0];
        end
    end

endmodule : div_step

// File: rtl/my_div36.sv
// Sequential restoring divider: 2*WIDTH-bit dividend / WIDTH-bit divisor,
// one quotient bit per clock, level-held calc_start / done handshake.
module my_div36
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               calc_start,
    input  logic [2*WIDTH-1:0] dataa,
    input  logic [WIDTH-1:0]   datab,
    output logic [WIDTH-1:0]   quotient,
    output logic [WIDTH-1:0]   remainder,
    output logic               done,
    output logic               div_zero,
    output logic               overflow
);

    localparam int CW = $clog2(WIDTH + 1);

    div_state_e         state_r;
    div_state_e         state_next_s;
    logic [2*WIDTH-1:0] dividend_r;
    logic [WIDTH-1:0]   divisor_r;
    logic [WIDTH-1:0]   part_rem_r;
    logic [WIDTH-1:0]   low_shift_r;
    logic [WIDTH-1:0]   quo_shift_r;
    logic [CW-1:0]      count_r;
    // Set once operands have been captured by a calc_start=0 edge; a run
    // only starts from captured operands, never from reset zeros.
    logic               armed_r;

    logic [WIDTH-1:0]   step_rem_s;
    logic               step_qbit_s;
    logic [WIDTH-1:0]   quo_next_s;
    logic               is_zero_s;
    logic               is_ovf_s;
    logic               last_step_s;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (part_rem_r),
        .in_bit   (low_shift_r[WIDTH-1]),
        .divisor  (divisor_r),
        .rem_next (step_rem_s),
        .qbit     (step_qbit_s)
    );

    // Operand checks and iteration bookkeeping derived from the held registers.
    always_comb begin
        is_zero_s   = (divisor_r == {WIDTH{1'b0}});
        is_ovf_s    = (dividend_r[2*WIDTH-1:WIDTH] >= divisor_r);
        last_step_s = (count_r == CW'(WIDTH - 1));
        quo_next_s  = {quo_shift_r[WIDTH-2:0], step_qbit_s};
    end

    // State register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; the zero/overflow decision is taken on the edge that
    // leaves IDLE so the first quotient bit lands on the following edge.
    always_comb begin
        state_next_s = state_r;
        if (!calc_start) begin
            state_next_s = IDLE;
        end else begin
            case (state_r)
                IDLE, CHECK: begin
                    if (!armed_r) begin
                        state_next_s = IDLE;
                    end else if (is_zero_s || is_ovf_s) begin
                        state_next_s = DONE;
                    end else begin
                        state_next_s = RUN;
                    end
                end
                RUN: begin
                    if (last_step_s) begin
                        state_next_s = DONE;
                    end else begin
                        state_next_s = RUN;
                    end
                end
                DONE:    state_next_s = DONE;
                default: state_next_s = IDLE;
            endcase
        end
    end

    // Operand capture, iteration datapath and registered result outputs.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            dividend_r  <= {(2*WIDTH){1'b0}};
            divisor_r   <= {WIDTH{1'b0}};
            part_rem_r  <= {WIDTH{1'b0}};
            low_shift_r <= {WIDTH{1'b0}};
            quo_shift_r <= {WIDTH{1'b0}};
            count_r     <= {CW{1'b0}};
            armed_r     <= 1'b0;
            quotient    <= {WIDTH{1'b0}};
            remainder   <= {WIDTH{1'b0}};
            done        <= 1'b0;
            div_zero    <= 1'b0;
            overflow    <= 1'b0;
        end else if (!calc_start) begin
            dividend_r  <= dataa;
            divisor_r   <= datab;
            part_rem_r  <= {WIDTH{1'b0}};
            low_shift_r <= {WIDTH{1'b0}};
            quo_shift_r <= {WIDTH{1'b0}};
            count_r     <= {CW{1'b0}};
            armed_r     <= 1'b1;
            quotient    <= {WIDTH{1'b0}};
            remainder   <= {WIDTH{1'b0}};
            done        <= 1'b0;
            div_zero    <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            case (state_r)
                IDLE, CHECK: begin
                    if (armed_r) begin
                        armed_r <= 1'b0;
                        if (is_zero_s) begin
                            div_zero  <= 1'b1;
                            quotient  <= {WIDTH{1'b1}};
                            remainder <= {WIDTH{1'b0}};
                            done      <= 1'b1;
                        end else if (is_ovf_s) begin
                            overflow  <= 1'b1;
                            quotient  <= {WIDTH{1'b1}};
                            remainder <= {WIDTH{1'b0}};
                            done      <= 1'b1;
                        end else begin
                            part_rem_r  <= dividend_r[2*WIDTH-1:WIDTH];
                            low_shift_r <= dividend_r[WIDTH-1:0];
                            quo_shift_r <= {WIDTH{1'b0}};
                            count_r     <= {CW{1'b0}};
                        end
                    end
                end
                RUN: begin
                    part_rem_r  <= step_rem_s;
                    quo_shift_r <= quo_next_s;
                    low_shift_r <= {low_shift_r[WIDTH-2:0], 1'b0};
                    count_r     <= count_r + {{(CW-1){1'b0}}, 1'b1};
                    if (last_step_s) begin
                        quotient  <= quo_next_s;
                        remainder <= step_rem_s;
                        done      <= 1'b1;
                    end
                end
                DONE: begin
                    done <= 1'b1;
                end
                default: begin
                    done <= 1'b0;
                end
            endcase
        end
    end

endmodule : my_div36

// File: tb/tb_my_div36.sv
// Directed and randomised checks for the restoring divider (WIDTH=18).
module tb_my_div36;

    localparam int W = 18;

    logic           CLK;
    logic           RST;
    logic           calc_start;
    logic [2*W-1:0] dataa;
    logic [W-1:0]   datab;
    logic [W-1:0]   quotient;
    logic [W-1:0]   remainder;
    logic           done;
    logic           div_zero;
    logic           overflow;

    int n_tests = 0;
    int n_fail  = 0;

    my_div36 dut (
        .CLK        (CLK),
        .RST        (RST),
        .calc_start (calc_start),
        .dataa      (dataa),
        .datab      (datab),
        .quotient   (quotient),
        .remainder  (remainder),
        .done       (done),
        .div_zero   (div_zero),
        .overflow   (overflow)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [2*W-1:0] a;
        logic [W-1:0]   b;
        logic [W-1:0]   q;
        logic [W-1:0]   r;
        logic           dz;
        logic           ov;
        int             lat;
    } vec_t;

    vec_t vecs[10];

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Load operands on one calc_start=0 edge, then run until done (bounded).
    // Operand inputs are scrambled after the start edge; the DUT must ignore them.
    task automatic run_op(input logic [2*W-1:0] a, input logic [W-1:0] b, output int lat);
        calc_start = 1'b0;
        dataa      = a;
        datab      = b;
        tick();
        calc_start = 1'b1;
        tick();
        lat   = 1;
        dataa = {$urandom, $urandom};
        datab = W'($urandom);
        while (!done && lat < 40) begin
            tick();
            lat++;
        end
        if (!done) lat = -1;
    endtask

    initial begin
        int lat;
        vecs[0] = '{36'd100,        18'd7,       18'd14,      18'd2,       1'b0, 1'b0, 19};
        vecs[1] = '{36'hFFFFBFFFF,  18'h3FFFF,   18'h3FFFF,   18'h3FFFE,   1'b0, 1'b0, 19};
        vecs[2] = '{36'd123,        18'd0,       18'h3FFFF,   18'd0,       1'b1, 1'b0, 1};
        vecs[3] = '{36'h000040000,  18'd1,       18'h3FFFF,   18'd0,       1'b0, 1'b1, 1};
        vecs[4] = '{36'd0,          18'd5,       18'd0,       18'd0,       1'b0, 1'b0, 19};
        vecs[5] = '{36'd1000000,    18'd1000,    18'd1000,    18'd0,       1'b0, 1'b0, 19};
        vecs[6] = '{36'd262143,     18'd2,       18'd131071,  18'd1,       1'b0, 1'b0, 19};
        vecs[7] = '{36'd1048576,    18'd5,       18'd209715,  18'd1,       1'b0, 1'b0, 19};
        vecs[8] = '{36'd1310720,    18'd5,       18'h3FFFF,   18'd0,       1'b0, 1'b1, 1};
        vecs[9] = '{36'd0,          18'd0,       18'h3FFFF,   18'd0,       1'b1, 1'b0, 1};

        RST        = 1'b1;
        calc_start = 1'b0;
        dataa      = '0;
        datab      = '0;
        repeat (2) @(posedge CLK);
        #1;
        check("reset_done", done, 1'b0);
        check("reset_q", quotient, 18'd0);
        check("reset_r", remainder, 18'd0);
        check("reset_flags", {div_zero, overflow}, 2'b00);
        RST = 1'b0;
        tick();

        // Directed table.
        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].a, vecs[i].b, lat);
            check($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
            check($sformatf("vec%0d_q", i), quotient, vecs[i].q);
            check($sformatf("vec%0d_r", i), remainder, vecs[i].r);
            check($sformatf("vec%0d_dz", i), div_zero, vecs[i].dz);
            check($sformatf("vec%0d_ov", i), overflow, vecs[i].ov);
        end

        // Result held stable in DONE for 10 more cycles.
        run_op(36'd100, 18'd7, lat);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("hold_result", {done, quotient, remainder, div_zero, overflow},
                  {1'b1, 18'd14, 18'd2, 1'b0, 1'b0});
        end

        // Reset while holding a result clears outputs immediately.
        #1 RST = 1'b1;
        #1;
        check("rst_in_done", {done, quotient, remainder}, 37'd0);
        #1 RST = 1'b0;
        calc_start = 1'b0;
        tick();

        // Abort mid-run after edge 5: no result, done never pulses.
        dataa = 36'd100;
        datab = 18'd7;
        tick();
        calc_start = 1'b1;
        repeat (5) tick();
        calc_start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("abort_quiet", {done, quotient, remainder}, 37'd0);
        end
        run_op(36'd100, 18'd7, lat);
        check("rerun_latency", lat, 19);
        check("rerun_result", {quotient, remainder}, {18'd14, 18'd2});

        // Reset pulse at edge 10 of a run; start stays high afterwards.
        calc_start = 1'b0;
        dataa = 36'd100;
        datab = 18'd7;
        tick();
        calc_start = 1'b1;
        repeat (10) tick();
        #1 RST = 1'b1;
        #1;
        check("rst_mid_run", {done, quotient, remainder, div_zero, overflow}, 39'd0);
        #1 RST = 1'b0;
        for (int i = 0; i < 25; i++) begin
            tick();
            check("post_rst_no_result", {done, div_zero, overflow}, 3'd0);
        end

        // Random sweep against an arithmetic reference.
        for (int i = 0; i < 1000; i++) begin
            logic [W-1:0]   b;
            logic [W-1:0]   hi;
            logic [W-1:0]   lo;
            logic [2*W-1:0] a;
            longint unsigned eq;
            longint unsigned er;
            b  = W'($urandom_range(1, 262143));
            hi = W'($urandom_range(0, 32'(b) - 1));
            lo = W'($urandom_range(0, 262143));
            a  = {hi, lo};
            eq = 64'(a) / 64'(b);
            er = 64'(a) % 64'(b);
            run_op(a, b, lat);
            check("rand_latency", lat, 19);
            check("rand_q", quotient, eq);
            check("rand_r", remainder, er);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_my_div36
